// File: rtl/bcd_timer_pkg.sv
// Shared types, widths and helpers for the 2-digit BCD countdown timer.
package bcd_timer_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned BCD_MAX = 9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Saturate a 4-bit value to a legal BCD digit.
    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
        return (d > BCD_W'(BCD_MAX)) ? BCD_W'(BCD_MAX) : d;
    endfunction

endpackage

// File: rtl/bcd_down2.sv
// Two-digit BCD down counter with parallel load; holds at 00 instead of wrapping.
module bcd_down2
    import bcd_timer_pkg::*;
#(
    parameter int unsigned RST_TENS = 3,
    parameter int unsigned RST_ONES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BCD_W-1:0] load_tens,
    input  logic [BCD_W-1:0] load_ones,
    input  logic             en,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             is_zero,
    output logic             is_one
);

    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;

    assign is_zero = (tens_q == '0) && (ones_q == '0);
    assign is_one  = (tens_q == '0) && (ones_q == BCD_W'(1));
    assign tens    = tens_q;
    assign ones    = ones_q;

    // Next count: load wins over decrement; decrement is suppressed at 00.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (load) begin
            tens_d = load_tens;
            ones_d = load_ones;
        end else if (en && !is_zero) begin
            if (ones_q != '0) begin
                ones_d = ones_q - BCD_W'(1);
            end else begin
                ones_d = BCD_W'(BCD_MAX);
                tens_d = tens_q - BCD_W'(1);
            end
        end
    end

    // Digit registers with synchronous reset to the preset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q <= BCD_W'(RST_TENS);
            ones_q <= BCD_W'(RST_ONES);
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Run/pause/clear controller for a 2-digit BCD countdown timer.
module bcd_timer_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int unsigned PRESET_TENS = 3,
    parameter int unsigned PRESET_ONES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             set_en,
    input  logic [BCD_W-1:0] set_tens,
    input  logic [BCD_W-1:0] set_ones,
    output logic [BCD_W-1:0] out1,
    output logic [BCD_W-1:0] out0,
    output logic             running,
    output logic             done,
    output logic             done_pulse,
    output logic             alarm
);

    localparam logic [BCD_W-1:0] PresetT = BCD_W'(PRESET_TENS);
    localparam logic [BCD_W-1:0] PresetO = BCD_W'(PRESET_ONES);

    state_e           state_q;
    logic [BCD_W-1:0] start_tens_q, start_ones_q;
    logic             running_q, done_q, done_pulse_q, alarm_q;

    logic             cnt_load, cnt_en, cnt_zero, cnt_one;
    logic [BCD_W-1:0] cnt_load_tens, cnt_load_ones;
    logic [BCD_W-1:0] set_tens_c, set_ones_c;

    assign set_tens_c = clamp_digit(set_tens);
    assign set_ones_c = clamp_digit(set_ones);

    // Counter control decode; priority clear > start_stop > set_en > tick.
    always_comb begin
        cnt_load      = 1'b0;
        cnt_en        = 1'b0;
        cnt_load_tens = start_tens_q;
        cnt_load_ones = start_ones_q;
        if (clear) begin
            cnt_load      = 1'b1;
            cnt_load_tens = PresetT;
            cnt_load_ones = PresetO;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!start_stop && set_en) begin
                        cnt_load      = 1'b1;
                        cnt_load_tens = set_tens_c;
                        cnt_load_ones = set_ones_c;
                    end
                end
                StRun: begin
                    // A coincident start_stop pauses and drops the tick.
                    cnt_en = tick && !start_stop;
                end
                StPause: begin
                end
                StDone: begin
                    cnt_load = start_stop;
                end
            endcase
        end
    end

    bcd_down2 #(
        .RST_TENS(PRESET_TENS),
        .RST_ONES(PRESET_ONES)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_tens(cnt_load_tens),
        .load_ones(cnt_load_ones),
        .en       (cnt_en),
        .tens     (out1),
        .ones     (out0),
        .is_zero  (cnt_zero),
        .is_one   (cnt_one)
    );

    // Sequencing FSM with start register and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            start_tens_q <= PresetT;
            start_ones_q <= PresetO;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            if (clear) begin
                state_q      <= StIdle;
                start_tens_q <= PresetT;
                start_ones_q <= PresetO;
                running_q    <= 1'b0;
                done_q       <= 1'b0;
                alarm_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_stop) begin
                            // Starting from 00 would expire instantly; ignore it.
                            if (!cnt_zero) begin
                                state_q   <= StRun;
                                running_q <= 1'b1;
                            end
                        end else if (set_en) begin
                            start_tens_q <= set_tens_c;
                            start_ones_q <= set_ones_c;
                        end
                    end
                    StRun: begin
                        if (start_stop) begin
                            state_q   <= StPause;
                            running_q <= 1'b0;
                        end else if (tick && cnt_one) begin
                            state_q      <= StDone;
                            running_q    <= 1'b0;
                            done_q       <= 1'b1;
                            done_pulse_q <= 1'b1;
                            alarm_q      <= 1'b0;
                        end
                    end
                    StPause: begin
                        if (start_stop) begin
                            state_q   <= StRun;
                            running_q <= 1'b1;
                        end
                    end
                    StDone: begin
                        if (start_stop) begin
                            state_q <= StIdle;
                            done_q  <= 1'b0;
                            alarm_q <= 1'b0;
                        end else if (tick) begin
                            alarm_q <= ~alarm_q;
                        end
                    end
                endcase
            end
        end
    end

    assign running    = running_q;
    assign done       = done_q;
    assign done_pulse = done_pulse_q;
    assign alarm      = alarm_q;

endmodule
